// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
//
// Captures a parallel word on a read request and shifts it out serially,
// MSB first, with a frame strobe, a busy flag and a one-cycle completion
// pulse. Each serial bit is held for CLKDIV clock cycles.
//
// Parameters:
//   WIDTH  - word width in bits (>= 2)
//   CLKDIV - clock cycles per serial bit (>= 1)
//
// Ports:
//   clk    in   rising-edge clock, the only clock
//   rst    in   synchronous active-high reset
//   rout   in   read request, only looked at while idle
//   Datain in   parallel word, captured on the accepting edge
//   sdo    out  serial data, MSB first, 0 outside a frame
//   sframe out  high while the word is being shifted out
//   busy   out  high from acceptance until the cycle after done
//   done   out  one-cycle pulse after the last bit period
// -----------------------------------------------------------------------------

// Protocol invariants on the serializer outputs.
module word_serializer_checker (
  input logic clk,
  input logic rst,
  input logic sdo,
  input logic sframe,
  input logic busy,
  input logic done
);

  // A frame can only be in progress while the block reports busy.
  a_frame_implies_busy: assert property (@(posedge clk) disable iff (rst)
    sframe |-> busy);

  // The serial line is quiet whenever no frame is in progress.
  a_sdo_quiet_outside_frame: assert property (@(posedge clk) disable iff (rst)
    !sframe |-> !sdo);

  // The completion pulse happens outside the frame but while still busy.
  a_done_after_frame: assert property (@(posedge clk) disable iff (rst)
    done |-> (busy && !sframe && !sdo));

  // The completion pulse lasts exactly one cycle.
  a_done_single_cycle: assert property (@(posedge clk) disable iff (rst)
    done |=> !done);

endmodule

module word_serializer #(
  parameter int WIDTH  = 16,
  parameter int CLKDIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rout,
  input  logic [WIDTH-1:0] Datain,
  output logic             sdo,
  output logic             sframe,
  output logic             busy,
  output logic             done
);

  // Counter widths never drop below one bit, so CLKDIV=1 still has a
  // (constant-zero) divider register.
  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int CNT_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [DIV_W-1:0] div_q,    div_d;

  logic sdo_q,    sdo_d;
  logic sframe_q, sframe_d;
  logic busy_q,   busy_d;
  logic done_q,   done_d;

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      div_q    <= '0;
      sdo_q    <= 1'b0;
      sframe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      div_q    <= div_d;
      sdo_q    <= sdo_d;
      sframe_q <= sframe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: request acceptance, bit timing and shifting.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    div_d    = div_q;

    case (state_q)
      ST_IDLE: begin
        if (rout) begin
          shreg_d  = Datain;
          bitcnt_d = CNT_LAST;
          div_d    = '0;
          state_d  = ST_SHIFT;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          if (bitcnt_q == '0) begin
            // Last bit period over; counters are left as they are and
            // reloaded on the next acceptance.
            state_d = ST_DONE;
          end else begin
            shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            bitcnt_d = bitcnt_q - CNT_W'(1);
            div_d    = '0;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        shreg_d  = '0;
        bitcnt_d = '0;
        div_d    = '0;
      end
    endcase
  end

  // Output logic: decoded from the next state so the registered outputs
  // line up with the state they describe.
  always_comb begin
    sdo_d    = 1'b0;
    sframe_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_d)
      ST_IDLE: begin
        sdo_d    = 1'b0;
        sframe_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
      end

      ST_SHIFT: begin
        sdo_d    = shreg_d[WIDTH-1];
        sframe_d = 1'b1;
        busy_d   = 1'b1;
        done_d   = 1'b0;
      end

      ST_DONE: begin
        sdo_d    = 1'b0;
        sframe_d = 1'b0;
        busy_d   = 1'b1;
        done_d   = 1'b1;
      end

      default: begin
        sdo_d    = 1'b0;
        sframe_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
      end
    endcase
  end

  assign sdo    = sdo_q;
  assign sframe = sframe_q;
  assign busy   = busy_q;
  assign done   = done_q;

  word_serializer_checker u_checker (
    .clk    (clk),
    .rst    (rst),
    .sdo    (sdo_q),
    .sframe (sframe_q),
    .busy   (busy_q),
    .done   (done_q)
  );

endmodule

// File: tb/tb_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_serializer
//
// Drives two serializers (CLKDIV=1 and CLKDIV=4) from the same inputs.
// Every cycle both are compared with a frame-timing reference model; a
// vector table and hand-written sequences cover the specific scenarios.
// -----------------------------------------------------------------------------
module tb_word_serializer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         rout;
  logic [W-1:0] din;

  logic sdo1, sframe1, busy1, done1;
  logic sdo4, sframe4, busy4, done4;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(W), .CLKDIV(1)) dut1 (
    .clk(clk), .rst(rst), .rout(rout), .Datain(din),
    .sdo(sdo1), .sframe(sframe1), .busy(busy1), .done(done1)
  );

  word_serializer #(.WIDTH(W), .CLKDIV(4)) dut4 (
    .clk(clk), .rst(rst), .rout(rout), .Datain(din),
    .sdo(sdo4), .sframe(sframe4), .busy(busy4), .done(done4)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: per instance, whether a frame exists, the edge that
  // accepted it and the captured word. Outputs follow from the offset.
  bit           m_act  [2];
  int           m_k    [2];
  logic [W-1:0] m_word [2];
  int           dv     [2] = '{1, 4};

  // Expected {sdo, sframe, busy, done} for instance i after the current edge.
  function automatic logic [3:0] model_out(input int i);
    int off;
    int len;
    len = W * dv[i];
    off = cyc - m_k[i];
    if (!m_act[i] || off > len) return 4'b0000;
    if (off == len) return 4'b0011;
    return {m_word[i][W - 1 - off / dv[i]], 3'b110};
  endfunction

  task automatic check(input string nm, input int a, input int e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, a, e);
    end
  endtask

  // Apply inputs for one edge, advance the model, compare both DUTs.
  task automatic step(input logic r, input logic ro, input logic [W-1:0] d);
    rst = r; rout = ro; din = d;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_act[i] = 1'b0;
      end else if (ro && (!m_act[i] || (cyc - m_k[i]) >= W * dv[i] + 2)) begin
        m_act[i]  = 1'b1;
        m_k[i]    = cyc;
        m_word[i] = d;
      end
    end
    #1;
    check("model div1", {sdo1, sframe1, busy1, done1}, model_out(0));
    check("model div4", {sdo4, sframe4, busy4, done4}, model_out(1));
  endtask

  typedef struct {
    logic         r;
    logic         ro;
    logic [W-1:0] d;
    logic [3:0]   exp;   // {sdo, sframe, busy, done} on the CLKDIV=1 DUT
  } vec_t;

  vec_t tbl [21];

  initial begin
    logic [W-1:0] pat;
    logic [W-1:0] acc;
    int frames, done_off, ones, dones, nstart, nword, idle_between, prev_sf;
    int starts [4];
    logic [W-1:0] words [4];

    // Reset with request and all-ones data, then a single A5C3 frame.
    pat = 16'hA5C3;
    tbl[0] = '{1'b1, 1'b1, 16'hFFFF, 4'b0000};
    tbl[1] = '{1'b1, 1'b1, 16'hFFFF, 4'b0000};
    tbl[2] = '{1'b0, 1'b0, 16'h0000, 4'b0000};
    for (int i = 0; i < W; i++)
      tbl[3 + i] = '{1'b0, (i == 0), ((i == 0) ? pat : 16'h0000), {pat[W - 1 - i], 3'b110}};
    tbl[19] = '{1'b0, 1'b0, 16'h0000, 4'b0011};
    tbl[20] = '{1'b0, 1'b0, 16'h0000, 4'b0000};

    rst = 1'b1; rout = 1'b1; din = 16'hFFFF;

    for (int r = 0; r < 21; r++) begin
      step(tbl[r].r, tbl[r].ro, tbl[r].d);
      check("table", {sdo1, sframe1, busy1, done1}, tbl[r].exp);
    end

    // CLKDIV=4, word 20: 64-cycle frame, done 64 cycles after the first bit.
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    frames = 0; done_off = -1; acc = '0;
    for (int off = 0; off <= 65; off++) begin
      step(1'b0, (off == 0), ((off == 0) ? 16'd20 : 16'hFFFF));
      if (sframe4) frames++;
      if (sframe4 && (off % 4 == 0)) acc = {acc[W-2:0], sdo4};
      if (done4) done_off = off;
    end
    check("div4 frame length", frames, 64);
    check("div4 word", acc, 16'd20);
    check("div4 done offset", done_off, 64);

    // Capture FFFF, then change data and re-request mid-frame.
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    ones = 0; dones = 0;
    for (int off = 0; off < 22; off++) begin
      step(1'b0, (off == 0) || (off >= 4 && off <= 9), ((off == 0) ? 16'hFFFF : 16'h0000));
      if (sframe1 && sdo1) ones++;
      if (done1) dones++;
    end
    check("no-restart ones", ones, 16);
    check("no-restart done count", dones, 1);

    // rout held high: 0001 then 8000, back to back.
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    nstart = 0; nword = 0; idle_between = 0; prev_sf = 0; acc = '0;
    for (int j = 0; j < 40; j++) begin
      step(1'b0, 1'b1, ((j == 0) ? 16'h0001 : 16'h8000));
      if (sframe1 && !prev_sf) begin
        if (nstart < 4) starts[nstart] = cyc;
        nstart++;
      end
      if (sframe1) acc = {acc[W-2:0], sdo1};
      if (!sframe1 && prev_sf) begin
        if (nword < 4) words[nword] = acc;
        nword++;
      end
      if (nstart == 1 && !busy1) idle_between++;
      prev_sf = sframe1;
    end
    check("b2b frame count", (nword >= 2), 1);
    check("b2b spacing", starts[1] - starts[0], 18);
    check("b2b word0", words[0], 16'h0001);
    check("b2b word1", words[1], 16'h8000);
    check("b2b idle gap", idle_between, 1);

    // Reset part-way through a frame, then a clean new frame.
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    for (int off = 0; off < 8; off++)
      step(1'b0, (off == 0), 16'hB6F1);
    step(1'b1, 1'b0, 16'h0000);
    check("abort outputs", {sdo1, sframe1, busy1, done1}, 4'b0000);
    dones = 0;
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'b0, 16'h0000);
      if (done1) dones++;
    end
    check("abort no done", dones, 0);
    acc = '0; done_off = -1;
    for (int off = 0; off < 18; off++) begin
      step(1'b0, (off == 0), 16'h3C5A);
      if (sframe1) acc = {acc[W-2:0], sdo1};
      if (done1) done_off = off;
    end
    check("post-abort word", acc, 16'h3C5A);
    check("post-abort done offset", done_off, 16);

    // Random traffic against the model.
    step(1'b1, 1'b0, 16'h0000);
    for (int j = 0; j < 400; j++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0), W'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
